// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: first-word-fall-through FIFO that captures writeback-stage
// register writes and drains them through a valid/ready trace port.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   PCW, RegWriteW,     writeback-stage PC, write enable,
//   WriteRegW,          destination register
//   WriteData3W         and write data (captured when cap is set)
//   trace_clr           synchronous clear of FIFO, overflow flag and drop counter
//   trace_valid/ready   head-entry handshake
//   trace_pc/reg/data   head entry, combinational from storage
//   trace_count         occupancy 0..DEPTH
//   trace_overflow      sticky: an event was dropped while full
//   trace_drop_cnt      saturating count of dropped events
// Macro WB_TRACE_R0_EN: when defined, writes to r0 are captured too.
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PCW,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteRegW,
    input  logic [31:0]       WriteData3W,
    input  logic              trace_clr,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [4:0]        trace_reg,
    output logic [31:0]       trace_data,
    output logic [ADDR_W:0]   trace_count,
    output logic              trace_overflow,
    output logic [DROP_W-1:0] trace_drop_cnt
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] data;
    } entry_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    entry_t              mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic cap, pop, full, push, drop;

`ifdef WB_TRACE_R0_EN
    assign cap = RegWriteW;
`else
    assign cap = RegWriteW && (WriteRegW != 5'd0);
`endif

    assign trace_valid = (count_q != '0);
    assign full        = (count_q == FULL_CNT);
    assign pop         = trace_valid && trace_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push        = cap && (!full || pop);
    assign drop        = cap && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (trace_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!trace_clr && push) begin
            mem_q[wr_ptr_q] <= '{pc: PCW, rg: WriteRegW, data: WriteData3W};
        end
    end

    assign trace_pc       = mem_q[rd_ptr_q].pc;
    assign trace_reg      = mem_q[rd_ptr_q].rg;
    assign trace_data     = mem_q[rd_ptr_q].data;
    assign trace_count    = count_q;
    assign trace_overflow = ovf_q;
    assign trace_drop_cnt = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: vector table plus queue scoreboard for wb_trace_buffer.
// Ports: none (drives clk/rst and all DUT inputs).
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCW;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] WriteData3W;
    logic        trace_clr;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [4:0]  trace_count;
    logic        trace_overflow;
    logic [15:0] trace_drop_cnt;

    always #5 clk = ~clk;

    wb_trace_buffer dut (
        .clk(clk), .rst(rst),
        .PCW(PCW), .RegWriteW(RegWriteW),
        .WriteRegW(WriteRegW), .WriteData3W(WriteData3W),
        .trace_clr(trace_clr),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_reg(trace_reg),
        .trace_data(trace_data), .trace_count(trace_count),
        .trace_overflow(trace_overflow),
        .trace_drop_cnt(trace_drop_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        rw;
        logic [4:0]  rg;
        logic [31:0] pc;
        logic [31:0] data;
        logic        rdy;
        int          exp_count;
        logic        exp_valid;
    } vec_t;

    ent_t        sb[$];
    logic        m_ovf;
    logic [15:0] m_drop;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic is_cap(input logic rw, input logic [4:0] rg);
`ifdef WB_TRACE_R0_EN
        return rw;
`else
        return rw && (rg != 5'd0);
`endif
    endfunction

    task automatic model_clear();
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = '0;
    endtask

    // Drive one cycle: compare outputs against the scoreboard before the edge,
    // then update the scoreboard with what the edge should do.
    task automatic step(input logic rw, input logic [4:0] rg,
                        input logic [31:0] pc, input logic [31:0] data,
                        input logic rdy, input logic clr);
        logic p, full;
        ent_t e;
        RegWriteW   = rw;
        WriteRegW   = rg;
        PCW         = pc;
        WriteData3W = data;
        trace_ready = rdy;
        trace_clr   = clr;
        #1;
        chk("count", 64'(trace_count), 64'(sb.size()));
        chk("valid", 64'(trace_valid), 64'(sb.size() != 0));
        chk("overflow", 64'(trace_overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(trace_drop_cnt), 64'(m_drop));
        if (sb.size() != 0) begin
            chk("head", {27'd0, trace_pc, trace_reg} ^ 64'(trace_data),
                {27'd0, sb[0].pc, sb[0].rg} ^ 64'(sb[0].data));
        end
        if (clr) begin
            model_clear();
        end else begin
            p    = (sb.size() != 0) && rdy;
            full = (sb.size() == 16);
            if (p) sb.delete(0);
            if (is_cap(rw, rg)) begin
                if (!full || p) begin
                    e = '{pc: pc, rg: rg, data: data};
                    sb.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic capn(input int n, input logic rdy, input int base);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 5'((base + i) % 31 + 1), 32'h1000 + 32'((base + i) * 4),
                 $urandom, rdy, 1'b0);
        end
    endtask

    vec_t vt[8];

    initial begin
        rst = 1'b0;
        RegWriteW = 0; WriteRegW = 0; PCW = 0; WriteData3W = 0;
        trace_clr = 0; trace_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(trace_count), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_ovf", 64'(trace_overflow), 64'd0);
        chk("rst_drop", 64'(trace_drop_cnt), 64'd0);
        rst = 1'b1;

        vt[0] = '{1, 5'd8,  32'hBFC00000, 32'h11, 0, 1, 1};
        vt[1] = '{1, 5'd9,  32'hBFC00004, 32'h22, 0, 2, 1};
        vt[2] = '{1, 5'd10, 32'hBFC00008, 32'h33, 0, 3, 1};
        vt[3] = '{0, 5'd0,  32'h0,        32'h0,  1, 2, 1};
        vt[4] = '{0, 5'd0,  32'h0,        32'h0,  1, 1, 1};
        vt[5] = '{0, 5'd0,  32'h0,        32'h0,  1, 0, 0};
`ifdef WB_TRACE_R0_EN
        vt[6] = '{1, 5'd0,  32'hBFC0000C, 32'h44, 0, 1, 1};
`else
        vt[6] = '{1, 5'd0,  32'hBFC0000C, 32'h44, 0, 0, 0};
`endif
        vt[7] = '{0, 5'd0,  32'h0,        32'h0,  1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step(vt[i].rw, vt[i].rg, vt[i].pc, vt[i].data, vt[i].rdy, 1'b0);
            chk($sformatf("vec%0d_count", i), 64'(trace_count),
                64'(vt[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 64'(trace_valid),
                64'(vt[i].exp_valid));
        end

        capn(16, 1'b0, 0);
        capn(2, 1'b0, 16);
        chk("full_count", 64'(trace_count), 64'd16);
        chk("full_ovf", 64'(trace_overflow), 64'd1);
        chk("full_drop", 64'(trace_drop_cnt), 64'd2);
        chk("full_head_pc", 64'(trace_pc), 64'h1000);
        step(1'b1, 5'd30, 32'hCAFE0000, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("fullpop_count", 64'(trace_count), 64'd16);
        chk("fullpop_drop", 64'(trace_drop_cnt), 64'd2);
        repeat (15) idle(1'b1);
        chk("last_pc", 64'(trace_pc), 64'hCAFE0000);
        chk("last_data", 64'(trace_data), 64'hDEADBEEF);
        idle(1'b1);
        chk("drained", 64'(trace_count), 64'd0);

        capn(5, 1'b0, 40);
        capn(40, 1'b1, 50);
        chk("wrap_count", 64'(trace_count), 64'd5);
        repeat (6) idle(1'b1);

        step(1'b0, 5'd0, 0, 0, 1'b0, 1'b1);
        capn(19, 1'b0, 3);
        repeat (11) idle(1'b1);
        chk("pre_clr_count", 64'(trace_count), 64'd5);
        chk("pre_clr_drop", 64'(trace_drop_cnt), 64'd3);
        step(1'b1, 5'd7, 32'h7777, 32'h7777, 1'b1, 1'b1);
        chk("clr_count", 64'(trace_count), 64'd0);
        chk("clr_ovf", 64'(trace_overflow), 64'd0);
        chk("clr_drop", 64'(trace_drop_cnt), 64'd0);
        chk("clr_valid", 64'(trace_valid), 64'd0);

        capn(4, 1'b0, 60);
        idle(1'b1);
        trace_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 64'(trace_valid), 64'd0);
        chk("async_count", 64'(trace_count), 64'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 5'd5, 32'h5555, 32'hA5A5, 1'b0, 1'b0);
        chk("post_rst_count", 64'(trace_count), 64'd1);
        chk("post_rst_pc", 64'(trace_pc), 64'h5555);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
